// File: rtl/rotleft_pkg.sv
// Shared constants and helpers for the rotleft rotator: default width,
// rotate-count width and a constant modulo helper.
package rotleft_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 20;
  localparam int unsigned CNT_W          = $clog2(DATA_WIDTH_DEF);

  // Exact unsigned remainder, usable in constant expressions and benches.
  function automatic int unsigned mod_width(input longint unsigned value,
                                            input int unsigned     width);
    return int'(value % longint'(width));
  endfunction

endpackage

// File: rtl/rot_mod_reduce.sv
// Reduces an unsigned rotate count modulo DATA_WIDTH with a restoring
// remainder, so any width >= 2 is exact, not only powers of two.
module rot_mod_reduce
  import rotleft_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned RED_W      = $clog2(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] amount_i,
  output logic [RED_W-1:0]      rem_o
);

  localparam logic [RED_W:0] MODV = (RED_W + 1)'(DATA_WIDTH);

  logic [RED_W:0] rem;

  // rem < DATA_WIDTH holds before each shift, so its top bit is always free.
  always_comb begin
    rem = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      rem = {rem[RED_W-1:0], amount_i[DATA_WIDTH-1-i]};
      if (rem >= MODV) rem = rem - MODV;
    end
    rem_o = rem[RED_W-1:0];
  end

endmodule

// File: rtl/rotleft.sv
// Registered left rotator: count reduced mod DATA_WIDTH, log-depth barrel,
// single output register with asynchronous active-low clear.
module rotleft
  import rotleft_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] shift_amount,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int unsigned RED_W = $clog2(DATA_WIDTH);

  logic [RED_W-1:0]      k;
  logic [DATA_WIDTH-1:0] stage [RED_W+1];
  logic [DATA_WIDTH-1:0] data_d;
  logic [DATA_WIDTH-1:0] data_q;

  rot_mod_reduce #(
    .DATA_WIDTH (DATA_WIDTH),
    .RED_W      (RED_W)
  ) u_reduce (
    .amount_i (shift_amount),
    .rem_o    (k)
  );

  assign stage[0] = data_in;

  // 2**j < DATA_WIDTH for every stage, so each step is a non-trivial rotate.
  for (genvar j = 0; j < RED_W; j++) begin : g_barrel
    localparam int unsigned SH = (2 ** j) % DATA_WIDTH;
    logic [DATA_WIDTH-1:0] rotated;
    assign rotated      = (stage[j] << SH) | (stage[j] >> (DATA_WIDTH - SH));
    assign stage[j + 1] = k[j] ? rotated : stage[j];
  end

  always_comb begin
    data_d = stage[RED_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign data_out = data_q;

endmodule

// File: tb/tb_rotleft.sv
// Self-checking bench for rotleft: directed vectors, reset behaviour and
// seeded random counts against an arithmetic rotate model.
module tb_rotleft;
  import rotleft_pkg::*;

  localparam int unsigned W = 20;
  localparam logic [W-1:0] PAT = 20'hEC880;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] data_in;
  logic [W-1:0] shift_amount;
  logic [W-1:0] data_out;

  int unsigned tests;
  int unsigned fails;

  rotleft #(.DATA_WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .shift_amount (shift_amount),
    .data_out     (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_rot(input logic [W-1:0] d,
                                           input logic [W-1:0] sa);
    longint unsigned wide;
    longint unsigned mask;
    int unsigned     kk;
    kk   = mod_width(longint'(sa), W);
    mask = (64'd1 << W) - 64'd1;
    wide = longint'(d);
    wide = ((wide << kk) | (wide >> (W - kk))) & mask;
    return wide[W-1:0];
  endfunction

  task automatic check(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Apply inputs away from the edge, then sample 1 time unit after it.
  task automatic step(input string tag, input logic [W-1:0] d,
                      input logic [W-1:0] sa, input logic [W-1:0] exp);
    @(negedge clk);
    data_in      = d;
    shift_amount = sa;
    @(posedge clk);
    #1;
    check(tag, data_out, exp);
  endtask

  initial begin
    logic [W-1:0] held;
    logic [W-1:0] d;
    logic [W-1:0] sa;
    tests = 0;
    fails = 0;
    void'($urandom(32'd20250611));

    rst_n        = 1'b1;
    data_in      = PAT;
    shift_amount = 20'd3;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async", data_out, 20'h00000);

    @(negedge clk);
    rst_n        = 1'b1;
    shift_amount = 20'd0;
    @(posedge clk);
    #1;
    check("first_after_reset_k0", data_out, 20'hEC880);

    step("k20",    PAT, 20'd20,     20'hEC880);
    step("k1",     PAT, 20'd1,      20'hD9101);
    step("k21",    PAT, 20'd21,     20'hD9101);
    step("k4",     PAT, 20'd4,      20'hC880E);
    step("kFFFFF", PAT, 20'hFFFFF,  20'h07644);
    step("k40",    PAT, 20'd40,     20'hEC880);
    step("k19",    PAT, 20'd19,     ref_rot(PAT, 20'd19));

    // Inputs changing between edges must not disturb the held result.
    held = data_out;
    @(negedge clk);
    data_in      = 20'h12345;
    shift_amount = 20'd7;
    #2;
    check("hold_between_edges", data_out, held);
    @(posedge clk);
    #1;
    check("after_hold_edge", data_out, ref_rot(20'h12345, 20'd7));

    for (int i = 0; i < 16; i++) begin
      d  = W'($urandom);
      sa = W'($urandom);
      step($sformatf("rand%0d", i), d, sa, ref_rot(d, sa));
    end

    // Mid-stream reset pulse clears immediately, then streaming resumes.
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midstream_reset", data_out, 20'h00000);
    @(posedge clk);
    #1;
    check("reset_held_over_edge", data_out, 20'h00000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d  = W'($urandom);
      sa = W'($urandom);
      step($sformatf("post_reset%0d", i), d, sa, ref_rot(d, sa));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
